// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, state type and hex decode table for 7-segment display users
// Contents: SEG_BLANK / AN_OFF idle codes, scan FSM state type, hex_to_seg() decode helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_e;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// rtl/seg7_scan_controller_if.sv - write port and display pins of the 7-segment scan controller
// Signals: wr_en/wr_addr/wr_data/wr_dp (digit register write), digit_en (per-digit enable),
//          seg/dp/an (active-low display pins), frame_done (end-of-frame pulse).
// Modports: master = upstream writer / board side, slave = scan controller.
interface seg7_scan_controller_if;

    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [3:0] digit_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, wr_dp, digit_en,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_dp, digit_en,
        output seg, dp, an, frame_done
    );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
// Ports: hex_i [3:0] nibble in, seg_o [6:0] active-low {g,f,e,d,c,b,a} out.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - 4-digit multiplexed 7-segment scan controller with inter-digit blanking
// Ports: clk, rst (sync, active-high), disp (seg7_scan_controller_if.slave):
//        write port into the 4-entry digit register file, digit_en, registered seg/dp/an pins, frame_done.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_controller_if.slave disp
);

    // A zero-length blank phase would let the previous digit's anode overlap the next.
    localparam int BLANK_EFF = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
    localparam int MAX_LEN   = (ON_CYCLES > BLANK_EFF) ? ON_CYCLES : BLANK_EFF;
    localparam int CW        = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_EFF - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] nib_q;
    logic [3:0]      dpen_q;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;
    logic            fd_q, fd_d;

    logic            phase_last;
    logic            bypass;
    logic [3:0]      lat_nib;
    logic            lat_dp;
    logic [6:0]      lat_seg;

    assign phase_last = (state_q == ST_BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == ON_LAST);

    // A write landing on the digit being latched is forwarded so the new value shows immediately.
    assign bypass  = disp.wr_en && (disp.wr_addr == idx_q);
    assign lat_nib = bypass ? disp.wr_data : nib_q[idx_q];
    assign lat_dp  = bypass ? disp.wr_dp   : dpen_q[idx_q];

    hex_to_seg7 u_dec (
        .hex_i (lat_nib),
        .seg_o (lat_seg)
    );

    // Output registers are loaded from the next-state view so the pins change on the
    // same edge as the FSM, keeping an/seg aligned with the phase boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = AN_OFF;
        fd_d    = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (phase_last) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    seg_d   = lat_seg;
                    dp_d    = ~lat_dp;
                end
            end
            ST_ON: begin
                if (phase_last) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    fd_d    = (idx_q == 2'd3);
                end else begin
                    // Hold the latched word so writes to the lit digit cannot tear it.
                    seg_d = seg_q;
                    dp_d  = dp_q;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // idx only advances when leaving ON, so idx_q is the lit slot whenever state_d is ON.
        if ((state_d == ST_ON) && disp.digit_en[idx_q]) begin
            an_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            dpen_q  <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
            if (disp.wr_en) begin
                nib_q[disp.wr_addr]  <= disp.wr_data;
                dpen_q[disp.wr_addr] <= disp.wr_dp;
            end
        end
    end

    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.an         = an_q;
    assign disp.frame_done = fd_q;

endmodule
